mnist_frame_loader: RTL
=======================

# mnist_frame_loader

Streaming writer that fills the CNN input image memory and launches inference. It accepts 8-bit grayscale pixels over a valid/ready/last stream, converts each to the pipeline's signed fixed-point format, and drives the image memory write port (`mnist_waddr`/`mnist_wen`/`mnist_wdata`) in raster order. After a complete, well-framed image it pulses the start to the top level. It then holds off the stream until the classifier reports completion.

## Interface
- DATA_WIDTH, 27, fixed-point word width written to image memory
- FRACTION_WIDTH, 9, fractional bits of the fixed-point word; must be ≥ 8
- ADDR_WIDTH, 10, image memory address width
- NUM_PIXELS, 784, pixels per frame (28×28); must be ≤ 2^ADDR_WIDTH
- FRAME_CNT_WIDTH, 16, width of the completed-frame counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_valid  in  1  pixel beat valid
- s_ready  out  1  loader accepts beat
- s_data  in  8  unsigned pixel, 0..255
- s_last  in  1  marks final pixel of a frame
- mnist_waddr  out  ADDR_WIDTH  image memory write address
- mnist_wen  out  1  image memory write enable
- mnist_wdata  out  DATA_WIDTH  converted pixel
- start_out  out  1  one-cycle inference start pulse
- cnn_done  in  1  one-cycle pulse: classification valid
- busy  out  1  high in any state other than IDLE
- frame_err  out  1  sticky framing-error flag
- frame_count  out  FRAME_CNT_WIDTH  completed inferences, wraps

## Operation
- Clock and reset: reset is synchronous and active-high; clock is clk.
- A beat is accepted when s_valid & s_ready are both high in the same cycle.
- Pixel counter `idx` runs 0..NUM_PIXELS-1. It is 0 in IDLE.
- Conversion: mnist_wdata = zero-extend(s_data) << (FRACTION_WIDTH-8). Value = pixel/256. The sign bit is always 0. There is no rounding and no saturation.
- States:
  - IDLE: s_ready=1. An accepted beat writes address 0 and goes to LOAD. If that beat has s_last=1 and NUM_PIXELS>1, it goes to IDLE instead with frame_err set.
  - LOAD: s_ready=1. Each accepted beat writes address idx, then idx increments.
    - Beat at idx=NUM_PIXELS-1 with s_last=1 → START.
    - Beat at idx=NUM_PIXELS-1 with s_last=0 → DRAIN, and frame_err is set.
    - Beat with s_last=1 and idx<NUM_PIXELS-1 → IDLE with frame_err set. The beat is still written. No start is issued.
  - DRAIN: s_ready=1. Beats are accepted and discarded (mnist_wen=0) until a beat with s_last=1, then IDLE.
  - START: s_ready=0. start_out=1 for exactly this cycle, then WAIT.
  - WAIT: s_ready=0. cnn_done=1 → IDLE, and frame_count increments.
- cnn_done is ignored in every state except WAIT.
- frame_err clears on the first accepted beat of the next frame, in IDLE. Set has priority over clear in the same cycle.
- A mid-frame idle gap (s_valid low) has no effect. The state holds indefinitely.

## Timing
- Reset values: s_ready=0 during reset, 1 in the first cycle after reset deasserts (IDLE). mnist_waddr=0, mnist_wen=0, mnist_wdata=0, start_out=0, busy=0, frame_err=0, frame_count=0.
- Write port outputs are registered. A beat accepted in cycle N produces mnist_wen=1 with its address and data in cycle N+1. mnist_wen is 1 for exactly one cycle per written beat.
- s_ready is combinational from state only, never from s_valid.
- start_out asserts in the cycle after the final write beat is visible on the write port. The memory write of the last pixel therefore completes before start.
- Best case for a full frame: NUM_PIXELS accept cycles + 1 START cycle.
- frame_count updates in the cycle after cnn_done is sampled in WAIT. busy drops in that same cycle.
- Reset mid-frame: return to IDLE next cycle with all outputs at reset values. The partial frame is abandoned and no start is issued.

## Test plan
- Nominal frame: 784 beats with s_valid held high, pixel = idx mod 256, s_last on beat 783.
  - Expect 784 writes at addresses 0..783, with wdata = (idx mod 256)<<1 (e.g. pixel 255 → 0x1FE).
  - Expect start_out high once, 1 cycle after the write to 783.
  - Pulse cnn_done 50 cycles later → frame_count=1, busy=0.
- Backpressure and gaps: random s_valid gaps during the frame.
  - Expect the same addresses and data as the nominal frame, with no duplicate or dropped writes.
  - During START/WAIT, beats offered get s_ready=0 and are not consumed.
- Short frame: s_last on beat 99.
  - Expect 100 writes, frame_err=1, no start_out, return to IDLE.
  - A following good frame clears frame_err on its first beat and completes normally.
- Long frame: s_last missing until beat 799.
  - Expect writes only for 0..783, frame_err=1, DRAIN consumes 16 beats, no start_out.
- Reset mid-frame at beat 400.
  - Expect all outputs to return to reset values, frame_count held at 0.
  - The next full frame starts writing at address 0.
- Spurious cnn_done in IDLE and LOAD: no state change and frame_count unchanged. Two back-to-back frames → frame_count=2.

Source files
------------

// File: rtl/mnist_frame_loader.sv
// Purpose: fills the CNN image memory from an 8-bit pixel stream in raster order, then launches inference.
// Latency: accepted beat appears on the write port next cycle; start_out follows the last write by one cycle.
// Backpressure: s_ready drops from frame completion until cnn_done, and is low while reset is asserted.
module mnist_frame_loader #(
    parameter int DATA_WIDTH      = 27,
    parameter int FRACTION_WIDTH  = 9,
    parameter int ADDR_WIDTH      = 10,
    parameter int NUM_PIXELS      = 784,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [7:0]                 s_data,
    input  logic                       s_last,
    output logic [ADDR_WIDTH-1:0]      mnist_waddr,
    output logic                       mnist_wen,
    output logic [DATA_WIDTH-1:0]      mnist_wdata,
    output logic                       start_out,
    input  logic                       cnn_done,
    output logic                       busy,
    output logic                       frame_err,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    // Pixel p maps to p/256 in the fixed-point format: shift left by the extra fraction bits.
    localparam int                    FRAC_SHIFT = FRACTION_WIDTH - 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] idx_next;
    logic                  accept;
    logic                  wr_next;
    logic                  err_set;
    logic                  err_clr;
    logic                  done_take;
    logic [DATA_WIDTH-1:0] pixel_fx;

    // Ready depends only on state (and reset), never on s_valid.
    assign s_ready  = !reset && (state == IDLE || state == LOAD || state == DRAIN);
    assign accept   = s_valid && s_ready;
    assign busy     = (state != IDLE);
    assign pixel_fx = DATA_WIDTH'(s_data) << FRAC_SHIFT;
    // Only the first beat of a frame, seen in IDLE, clears a previous framing error.
    assign err_clr  = accept && (state == IDLE);

    // Next-state, write request and event decode; IDLE behaves like LOAD at idx 0.
    always_comb begin
        state_next = state;
        wr_next    = 1'b0;
        err_set    = 1'b0;
        done_take  = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    wr_next = 1'b1;
                    if (idx == LAST_IDX) begin
                        if (s_last) begin
                            state_next = START;
                        end else begin
                            state_next = DRAIN;
                            err_set    = 1'b1;
                        end
                    end else if (s_last) begin
                        state_next = IDLE;
                        err_set    = 1'b1;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_next = IDLE;
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (cnn_done) begin
                    state_next = IDLE;
                    done_take  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // idx is non-zero only while a frame is being loaded.
        if (state_next == LOAD) begin
            idx_next = accept ? (idx + ADDR_WIDTH'(1)) : idx;
        end else begin
            idx_next = '0;
        end
    end

    // State and pixel index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Registered memory write port; address/data hold between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            mnist_wen   <= 1'b0;
            mnist_waddr <= '0;
            mnist_wdata <= '0;
        end else begin
            mnist_wen <= wr_next;
            if (wr_next) begin
                mnist_waddr <= idx;
                mnist_wdata <= pixel_fx;
            end
        end
    end

    // Start is registered off START so it trails the final write on the port by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_out <= 1'b0;
        end else begin
            start_out <= (state == START);
        end
    end

    // Sticky framing error; a new error wins over the clear of the same beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else if (err_set) begin
            frame_err <= 1'b1;
        end else if (err_clr) begin
            frame_err <= 1'b0;
        end
    end

    // Completed-inference counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (done_take) begin
            frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
        end
    end

endmodule
